// File: rtl/matrix_bank.sv
// matrix_bank: N_SLOTS matrix store with user and ALU element/dimension ports
// and an internal engine that clears a slot or copies one slot to another.
module matrix_bank #(
  parameter int unsigned N_SLOTS = 4,
  parameter int unsigned MAX_DIM = 5,
  parameter int unsigned DW      = 16,
  parameter int unsigned SW      = $clog2(N_SLOTS),
  parameter int unsigned IW      = $clog2(MAX_DIM + 1)
) (
  input  logic               clk,
  input  logic               rst,
  // user port
  input  logic [SW-1:0]      u_slot,
  input  logic [IW-1:0]      u_row,
  input  logic [IW-1:0]      u_col,
  input  logic [DW-1:0]      u_data,
  input  logic               u_we,
  input  logic [IW-1:0]      u_dim_m,
  input  logic [IW-1:0]      u_dim_n,
  input  logic               u_dim_we,
  output logic [DW-1:0]      u_rd_data,
  output logic [IW-1:0]      u_cur_m,
  output logic [IW-1:0]      u_cur_n,
  // ALU read port
  input  logic [SW-1:0]      a_rd_slot,
  input  logic [IW-1:0]      a_rd_row,
  input  logic [IW-1:0]      a_rd_col,
  output logic [DW-1:0]      a_rd_data,
  output logic [IW-1:0]      a_cur_m,
  output logic [IW-1:0]      a_cur_n,
  // ALU write port
  input  logic [SW-1:0]      a_wr_slot,
  input  logic [IW-1:0]      a_wr_row,
  input  logic [IW-1:0]      a_wr_col,
  input  logic [DW-1:0]      a_wr_data,
  input  logic               a_wr_we,
  input  logic [IW-1:0]      a_res_m,
  input  logic [IW-1:0]      a_res_n,
  input  logic               a_dim_we,
  // status
  output logic [N_SLOTS-1:0] slot_valid,
  // slot engine
  input  logic               eng_req,
  input  logic               eng_op,
  input  logic [SW-1:0]      eng_src,
  input  logic [SW-1:0]      eng_dst,
  output logic               eng_busy,
  output logic               eng_done,
  output logic               err_oob,
  output logic               err_coll
);

  localparam int unsigned SLOT_WORDS = MAX_DIM * MAX_DIM;
  localparam int unsigned DEPTH      = N_SLOTS * SLOT_WORDS;
  localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned KW         = (SLOT_WORDS > 1) ? $clog2(SLOT_WORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Element address, formed at 32 bits before narrowing to the array index.
  function automatic logic [AW-1:0] f_addr(input logic [SW-1:0] slot,
                                           input logic [IW-1:0] row,
                                           input logic [IW-1:0] col);
    logic [31:0] w_full;
    w_full = 32'(slot) * 32'(SLOT_WORDS) + 32'(row) * 32'(MAX_DIM) + 32'(col);
    return AW'(w_full);
  endfunction

  // Engine address: linear element index k within a slot.
  function automatic logic [AW-1:0] f_eng_addr(input logic [SW-1:0] slot,
                                               input logic [KW-1:0] k);
    logic [31:0] w_full;
    w_full = 32'(slot) * 32'(SLOT_WORDS) + 32'(k);
    return AW'(w_full);
  endfunction

  function automatic logic f_slot_ok(input logic [SW-1:0] slot);
    return 32'(slot) < N_SLOTS;
  endfunction

  function automatic logic f_idx_ok(input logic [IW-1:0] idx);
    return 32'(idx) < MAX_DIM;
  endfunction

  function automatic logic f_dim_ok(input logic [IW-1:0] dim);
    return 32'(dim) <= MAX_DIM;
  endfunction

  logic [DW-1:0] r_mem   [DEPTH];
  logic [IW-1:0] r_dim_m [N_SLOTS];
  logic [IW-1:0] r_dim_n [N_SLOTS];
  logic [N_SLOTS-1:0] r_valid;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_op;
  logic [SW-1:0] r_src;
  logic [SW-1:0] r_dst;
  logic [KW-1:0] r_k;
  logic          r_busy;
  logic          r_done;
  logic          r_err_oob;
  logic          r_err_coll;

  logic          w_start;
  logic          w_req_oob;
  logic          w_eng_we;
  logic          w_eng_last;
  logic          w_busy;
  logic [DW-1:0] w_eng_data;
  logic [IW-1:0] w_eng_m;
  logic [IW-1:0] w_eng_n;

  logic w_u_el_ok, w_a_el_ok, w_u_dim_ok, w_a_dim_ok;
  logic w_u_lock, w_a_lock, w_el_same;
  logic w_u_el_do, w_a_el_do, w_u_dim_do, w_a_dim_do;
  logic w_oob, w_coll;

  // Combinational read ports; out-of-range addresses read as zero.
  always_comb begin
    u_rd_data = '0;
    a_rd_data = '0;
    u_cur_m   = '0;
    u_cur_n   = '0;
    a_cur_m   = '0;
    a_cur_n   = '0;
    if (f_slot_ok(u_slot) && f_idx_ok(u_row) && f_idx_ok(u_col))
      u_rd_data = r_mem[f_addr(u_slot, u_row, u_col)];
    if (f_slot_ok(a_rd_slot) && f_idx_ok(a_rd_row) && f_idx_ok(a_rd_col))
      a_rd_data = r_mem[f_addr(a_rd_slot, a_rd_row, a_rd_col)];
    if (f_slot_ok(u_slot)) begin
      u_cur_m = r_dim_m[u_slot];
      u_cur_n = r_dim_n[u_slot];
    end
    if (f_slot_ok(a_rd_slot)) begin
      a_cur_m = r_dim_m[a_rd_slot];
      a_cur_n = r_dim_n[a_rd_slot];
    end
  end

  // Engine source data and the dimensions it leaves on the destination.
  always_comb begin
    w_eng_data = '0;
    w_eng_m    = '0;
    w_eng_n    = '0;
    if (r_op) begin
      w_eng_data = r_mem[f_eng_addr(r_src, r_k)];
      w_eng_m    = r_dim_m[r_src];
      w_eng_n    = r_dim_n[r_src];
    end
  end

  // Write arbitration: range checks, engine locks, ALU-over-user priority.
  always_comb begin
    w_busy     = (r_state == ST_RUN);
    w_u_el_ok  = f_slot_ok(u_slot) && f_idx_ok(u_row) && f_idx_ok(u_col);
    w_a_el_ok  = f_slot_ok(a_wr_slot) && f_idx_ok(a_wr_row) && f_idx_ok(a_wr_col);
    w_u_dim_ok = f_slot_ok(u_slot) && f_dim_ok(u_dim_m) && f_dim_ok(u_dim_n);
    w_a_dim_ok = f_slot_ok(a_wr_slot) && f_dim_ok(a_res_m) && f_dim_ok(a_res_n);
    w_u_lock   = w_busy && ((u_slot == r_dst) || (r_op && (u_slot == r_src)));
    w_a_lock   = w_busy && ((a_wr_slot == r_dst) || (r_op && (a_wr_slot == r_src)));
    w_el_same  = (u_slot == a_wr_slot) && (u_row == a_wr_row) && (u_col == a_wr_col);
    w_a_el_do  = a_wr_we && w_a_el_ok && !w_a_lock;
    w_u_el_do  = u_we && w_u_el_ok && !w_u_lock &&
                 !(a_wr_we && w_a_el_ok && w_el_same);
    w_a_dim_do = a_dim_we && w_a_dim_ok && !w_a_lock;
    w_u_dim_do = u_dim_we && w_u_dim_ok && !w_u_lock &&
                 !(a_dim_we && w_a_dim_ok && (u_slot == a_wr_slot));
    w_oob      = (u_we && !w_u_el_ok) || (a_wr_we && !w_a_el_ok) ||
                 (u_dim_we && !w_u_dim_ok) || (a_dim_we && !w_a_dim_ok) ||
                 w_req_oob;
    // an in-range write that did not happen lost to the engine or the ALU
    w_coll     = (u_we && w_u_el_ok && !w_u_el_do) ||
                 (a_wr_we && w_a_el_ok && !w_a_el_do) ||
                 (u_dim_we && w_u_dim_ok && !w_u_dim_do) ||
                 (a_dim_we && w_a_dim_ok && !w_a_dim_do);
  end

  // Engine state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Engine next-state and per-cycle controls.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_req_oob   = 1'b0;
    w_eng_we    = 1'b0;
    w_eng_last  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (eng_req) begin
          if (!f_slot_ok(eng_dst) || (eng_op && !f_slot_ok(eng_src))) begin
            w_req_oob = 1'b1;
          end else begin
            w_start     = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        w_eng_we = 1'b1;
        if (r_k == KW'(SLOT_WORDS - 1)) begin
          w_eng_last  = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latched engine request and element counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op  <= 1'b0;
      r_src <= '0;
      r_dst <= '0;
      r_k   <= '0;
    end else if (w_start) begin
      r_op  <= eng_op;
      r_src <= eng_src;
      r_dst <= eng_dst;
      r_k   <= '0;
    end else if (w_eng_we) begin
      r_k   <= r_k + KW'(1);
    end
  end

  // Registered status outputs and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err_oob  <= 1'b0;
      r_err_coll <= 1'b0;
    end else begin
      r_busy     <= (w_state_nxt == ST_RUN);
      r_done     <= (w_state_nxt == ST_DONE);
      r_err_oob  <= w_oob;
      r_err_coll <= w_coll;
    end
  end

  // Element storage; no reset, and nothing is written while rst is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_u_el_do) r_mem[f_addr(u_slot, u_row, u_col)] <= u_data;
      if (w_a_el_do) r_mem[f_addr(a_wr_slot, a_wr_row, a_wr_col)] <= a_wr_data;
      if (w_eng_we)  r_mem[f_eng_addr(r_dst, r_k)] <= w_eng_data;
    end
  end

  // Per-slot dimensions and valid flags; later writes take priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < N_SLOTS; s++) begin
        r_dim_m[s] <= '0;
        r_dim_n[s] <= '0;
      end
      r_valid <= '0;
    end else begin
      if (w_u_dim_do) begin
        r_dim_m[u_slot] <= u_dim_m;
        r_dim_n[u_slot] <= u_dim_n;
        r_valid[u_slot] <= (u_dim_m != '0) && (u_dim_n != '0);
      end
      if (w_a_dim_do) begin
        r_dim_m[a_wr_slot] <= a_res_m;
        r_dim_n[a_wr_slot] <= a_res_n;
        r_valid[a_wr_slot] <= (a_res_m != '0) && (a_res_n != '0);
      end
      if (w_eng_last) begin
        r_dim_m[r_dst] <= w_eng_m;
        r_dim_n[r_dst] <= w_eng_n;
        r_valid[r_dst] <= (w_eng_m != '0) && (w_eng_n != '0);
      end
    end
  end

  assign slot_valid = r_valid;
  assign eng_busy   = r_busy;
  assign eng_done   = r_done;
  assign err_oob    = r_err_oob;
  assign err_coll   = r_err_coll;

endmodule
